// File: rtl/tone_pkg.sv
// tone_pkg: shared FSM state type and default sizing for the tone sequencer
package tone_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, PLAY, FINISH} tone_state_t;
   localparam int NUM_NOTES_DEF = 8;
   localparam int DIV_W_DEF     = 16;
   localparam int DUR_W_DEF     = 8;
   localparam int TICK_DIV_DEF  = 100000;
endpackage

// File: rtl/tone_divider.sv
// tone_divider: loadable half-period divider producing the square wave
module tone_divider #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             speaker
);
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;
   logic             r_spk;
   // latch the divisor on load, then toggle every div cycles; a zero divisor is a rest
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div <= '0;
         r_cnt <= '0;
         r_spk <= 1'b0;
      end else if (load) begin
         r_div <= div;
         r_cnt <= div - 1'b1;
         r_spk <= 1'b0;
      end else if (r_div == '0) begin
         r_spk <= 1'b0;
      end else if (r_cnt == '0) begin
         r_cnt <= r_div - 1'b1;
         r_spk <= ~r_spk;
      end else begin
         r_cnt <= r_cnt - 1'b1;
      end
   end
   assign speaker = r_spk;
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a table of (half-period, duration) notes on one pin
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int NUM_NOTES = NUM_NOTES_DEF,
   parameter int DIV_W     = DIV_W_DEF,
   parameter int DUR_W     = DUR_W_DEF,
   parameter int TICK_DIV  = TICK_DIV_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         stop,
   input  logic [$clog2(NUM_NOTES):0]   seq_len,
   input  logic                         cfg_we,
   input  logic [$clog2(NUM_NOTES)-1:0] cfg_addr,
   input  logic [DIV_W-1:0]             cfg_div,
   input  logic [DUR_W-1:0]             cfg_dur,
   output logic                         speaker,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(NUM_NOTES)-1:0] note_idx
);
   localparam int IW = $clog2(NUM_NOTES);
   localparam int LW = IW + 1;
   localparam int PW = $clog2(TICK_DIV + 1);
   localparam logic [LW-1:0] MAX_LEN = LW'(NUM_NOTES);
   localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
   logic [DIV_W-1:0] r_tab_div [NUM_NOTES];
   logic [DUR_W-1:0] r_tab_dur [NUM_NOTES];
   tone_state_t      r_state;
   logic [IW-1:0]    r_idx;
   logic [LW-1:0]    r_len;
   logic [PW-1:0]    r_pre;
   logic [DUR_W-1:0] r_dur;
   logic             r_busy;
   logic             r_done;
   logic [DIV_W-1:0] w_div;
   logic [DUR_W-1:0] w_dur;
   logic             w_last;
   logic             w_wrap;
   logic             w_end;
   logic             w_load;
   assign w_div  = r_tab_div[r_idx];
   assign w_dur  = r_tab_dur[r_idx];
   assign w_last = {1'b0, r_idx} == r_len - 1'b1;
   assign w_wrap = r_pre == PRE_TOP;
   assign w_end  = (r_state == PLAY) && w_wrap && (r_dur == DUR_W'(1));
   // the divider is held loaded (silent, primed with the current entry) whenever no note is sounding
   assign w_load = stop || (r_state != PLAY) || w_end;
   // note table: writable at any time, never reset; reads see the pre-edge value
   always_ff @(posedge clk) begin
      if (cfg_we) begin
         r_tab_div[cfg_addr] <= cfg_div;
         r_tab_dur[cfg_addr] <= cfg_dur;
      end
   end
   // sequencing FSM with prescaler, duration counter and registered busy/done
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_len   <= '0;
         r_pre   <= '0;
         r_dur   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (stop) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: if (start && seq_len != '0) begin
                  r_state <= LOAD;
                  r_len   <= (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
               LOAD: if (w_dur != '0) begin
                  r_state <= PLAY;
                  r_dur   <= w_dur;
                  r_pre   <= '0;
               end else if (w_last) begin
                  r_state <= FINISH;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
               PLAY: begin
                  r_pre <= w_wrap ? '0 : r_pre + 1'b1;
                  if (w_wrap) r_dur <= r_dur - 1'b1;
                  if (w_end && w_last) begin
                     r_state <= FINISH;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (w_end) begin
                     r_state <= LOAD;
                     r_idx   <= r_idx + 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end
   tone_divider #(.DIV_W(DIV_W)) u_div (
      .clk     (clk),
      .reset   (reset),
      .load    (w_load),
      .div     (w_div),
      .speaker (speaker)
   );
   assign busy     = r_busy;
   assign done     = r_done;
   assign note_idx = r_idx;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: randomized and directed checks against a note-list reference model
module tb_tone_sequencer;
   localparam int T = 4;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        cfg_we = 1'b0;
   logic [3:0]  seq_len = '0;
   logic [2:0]  cfg_addr = '0;
   logic [15:0] cfg_div = '0;
   logic [7:0]  cfg_dur = '0;
   logic        speaker;
   logic        busy;
   logic        done;
   logic [2:0]  note_idx;
   logic [15:0] m_div [8];
   logic [7:0]  m_dur [8];
   int          n_chk = 0;
   int          n_fail = 0;
   int          nb;
   int          nd;
   typedef struct packed {
      logic       b;
      logic       d;
      logic       sv;
      logic       s;
      logic       iv;
      logic [2:0] i;
   } exp_t;

   tone_sequencer #(.NUM_NOTES(8), .DIV_W(16), .DUR_W(8), .TICK_DIV(T)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .seq_len  (seq_len),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_div  (cfg_div),
      .cfg_dur  (cfg_dur),
      .speaker  (speaker),
      .busy     (busy),
      .done     (done),
      .note_idx (note_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input int d, input int u);
      @(posedge clk); #1;
      cfg_we = 1'b1;
      cfg_addr = 3'(a);
      cfg_div = 16'(d);
      cfg_dur = 8'(u);
      m_div[a] = 16'(d);
      m_dur[a] = 8'(u);
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".done"}, done, 0);
      chk({tag, ".spk"}, speaker, 0);
   endtask

   // expected cycle list: per entry one LOAD cycle, then dur*T PLAY cycles, then one FINISH cycle
   task automatic run_seq(input int len, input int wat, input int wdiv, output int ob, output int od);
      exp_t q[$];
      exp_t e;
      int   n;
      n = (len > 8) ? 8 : len;
      for (int i = 0; i < n; i++) begin
         e = '{b: 1'b1, d: 1'b0, sv: 1'b0, s: 1'b0, iv: 1'b1, i: 3'(i)};
         q.push_back(e);
         for (int k = 0; k < int'(m_dur[i]) * T; k++) begin
            e.sv = 1'b1;
            e.s = (m_div[i] == 0) ? 1'b0 : 1'((k / int'(m_div[i])) % 2);
            q.push_back(e);
         end
      end
      e = '{b: 1'b0, d: 1'b1, sv: 1'b1, s: 1'b0, iv: 1'b0, i: 3'd0};
      q.push_back(e);
      ob = 0;
      od = 0;
      @(posedge clk); #1;
      seq_len = 4'(len);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
         if (i == wat) begin
            cfg_we = 1'b1;
            cfg_addr = 3'd0;
            cfg_div = 16'(wdiv);
            cfg_dur = m_dur[0];
            m_div[0] = 16'(wdiv);
         end
         @(negedge clk);
         chk("busy", busy, q[i].b);
         chk("done", done, q[i].d);
         if (q[i].sv) chk("spk", speaker, q[i].s);
         if (q[i].iv) chk("idx", note_idx, q[i].i);
         ob += int'(busy);
         od += int'(done);
         @(posedge clk); #1;
         cfg_we = 1'b0;
      end
      @(negedge clk);
      chk_idle("after");
   endtask

   // free-running timeline from a start pulse, with optional extra start and a stop cycle
   task automatic tl(input int len, input int restart_at, input int stop_at, input int window,
                     output int ob, output int od);
      ob = 0;
      od = 0;
      for (int c = 0; c < window; c++) begin
         @(posedge clk); #1;
         seq_len = 4'(len);
         start = (c == 0) || (c == restart_at);
         stop = (c == stop_at);
         @(negedge clk);
         ob += int'(busy);
         od += int'(done);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_idle("rst");
      chk("rst.idx", note_idx, 0);

      wr(0, 3, 2);
      run_seq(1, -1, 0, nb, nd);
      chk("single.busy_cycles", nb, 9);
      chk("single.done_pulses", nd, 1);

      wr(0, 0, 1);
      wr(1, 7, 0);
      wr(2, 2, 1);
      run_seq(3, -1, 0, nb, nd);
      chk("rest.busy_cycles", nb, 11);
      chk("rest.done_pulses", nd, 1);

      wr(0, 3, 5);
      tl(1, -1, 8, 9, nb, nd);
      chk("stop.busy_cycles", nb, 8);
      chk("stop.done_pulses", nd, 0);
      @(posedge clk); #1;
      stop = 1'b0;
      @(negedge clk);
      chk_idle("stop");
      chk("stop.idx", note_idx, 0);
      run_seq(1, -1, 0, nb, nd);
      chk("replay.busy_cycles", nb, 21);

      wr(0, 3, 2);
      tl(1, 4, -1, 14, nb, nd);
      chk("restart.busy_cycles", nb, 9);
      chk("restart.done_pulses", nd, 1);
      tl(0, -1, -1, 8, nb, nd);
      chk("len0.busy_cycles", nb, 0);
      chk("len0.done_pulses", nd, 0);
      tl(1, -1, 0, 8, nb, nd);
      chk("startstop.busy_cycles", nb, 0);
      chk("startstop.done_pulses", nd, 0);

      run_seq(1, 3, 5, nb, nd);
      run_seq(1, -1, 0, nb, nd);

      wr(0, 1, 3);
      tl(1, -1, -1, 6, nb, nd);
      chk("midplay.busy", busy, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk_idle("rst2");
      chk("rst2.idx", note_idx, 0);
      run_seq(1, -1, 0, nb, nd);

      for (int a = 0; a < 8; a++) wr(a, a + 1, 1);
      run_seq(15, -1, 0, nb, nd);
      chk("clamp.busy_cycles", nb, 8 * (1 + T));

      repeat (20) begin
         for (int a = 0; a < 8; a++)
            wr(a, $urandom_range(0, 6), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3));
         run_seq($urandom_range(1, 12), -1, 0, nb, nd);
         chk("rand.done_pulses", nd, 1);
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
